dma_channel_arbiter: RTL

// - Registered, parametrised channel arbiter for the AHB DMA controller. Selects one of
//   N_CH requesting channels to own the AHB master port and holds the grant until release.
// - Arbitration is programmable-priority with round-robin tie-break. Priority can be

---
 rtl/dma_channel_arbiter_if.sv | 33 +++
 rtl/dma_channel_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter_if.sv
// Bus bundle between the DMA channel register files / AHB master FSM and the
// channel arbiter.
// Handshake: req is a level per channel. A channel owns the bus from the edge where
// grant_valid=1 with its grant_id. It keeps ownership until one of three things
// happens: it drops req, advance is pulsed, or the beat quota expires while
// another channel is waiting. beat is a single-cycle pulse per completed data beat.
interface dma_channel_arbiter_if #(
    parameter int N_CH   = 31,
    parameter int CH_W   = (N_CH <= 1) ? 1 : $clog2(N_CH),
    parameter int PRIO_W = 2,
    parameter int Q_W    = 5
);
    logic [N_CH-1:0]        req;
    logic [N_CH*PRIO_W-1:0] prio;
    logic                   beat;
    logic                   advance;
    logic                   grant_valid;
    logic [CH_W-1:0]        grant_id;
    logic [N_CH-1:0]        grant_oh;
    logic [Q_W-1:0]         beat_cnt;

    // Channel / bus-master side: drives requests and beat progress.
    modport master (
        output req, prio, beat, advance,
        input  grant_valid, grant_id, grant_oh, beat_cnt
    );

    // Arbiter side.
    modport slave (
        input  req, prio, beat, advance,
        output grant_valid, grant_id, grant_oh, beat_cnt
    );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Registered programmable-priority arbiter with a round-robin tie-break for the
// AHB DMA channels. The grant is held until the owner is released, and an
// optional beat quota forces re-arbitration.
module dma_channel_arbiter #(
    parameter int N_CH    = 31,
    parameter int CH_W    = (N_CH <= 1) ? 1 : $clog2(N_CH),
    parameter int PRIO_W  = 2,
    parameter bit PRIO_EN = 1'b1,
    parameter int QUOTA   = 16,
    parameter int Q_W     = (QUOTA == 0) ? 1 : $clog2(QUOTA + 1)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    dma_channel_arbiter_if.slave  bus,
    output logic                  dbg_state_o
);

    typedef enum logic [0:0] { IDLE = 1'b0, OWN = 1'b1 } state_t;

    localparam logic [Q_W-1:0] CNT_MAX = '1;
    localparam logic [Q_W:0]   QUOTA_V = (Q_W + 1)'(QUOTA);
    localparam logic [CH_W-1:0] LAST_RST = CH_W'(N_CH - 1);

    state_t          state_q, state_d;
    logic [CH_W-1:0] grant_id_q, grant_id_d;
    logic [N_CH-1:0] grant_oh_q, grant_oh_d;
    logic [Q_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CH_W-1:0] last_ptr_q, last_ptr_d;

    logic [N_CH-1:0] req_m;
    logic [CH_W-1:0] arb_last;
    logic [CH_W-1:0] win;
    logic [N_CH-1:0] win_oh;
    logic [Q_W:0]    beat_sum;
    logic [Q_W-1:0]  cnt_inc;
    logic            owner_req;
    logic            quota_hit;
    logic            release_own;

    // Winner: the requesters at the highest priority (or all of them when priority
    // is disabled). Among those, pick the first one found by scanning upward from
    // last+1 with wrap-around.
    function automatic logic [CH_W-1:0] pick(input logic [N_CH-1:0]        r,
                                             input logic [CH_W-1:0]        last,
                                             input logic [N_CH*PRIO_W-1:0] p);
        logic [PRIO_W-1:0] maxp;
        logic [N_CH-1:0]   cand;
        logic [CH_W-1:0]   w;
        logic [CH_W-1:0]   idx_w;
        logic              found;
        int                idx;
        maxp  = '0;
        cand  = r;
        w     = '0;
        found = 1'b0;
        if (PRIO_EN) begin
            for (int i = 0; i < N_CH; i++) begin
                if (r[i] && (p[i*PRIO_W +: PRIO_W] > maxp)) maxp = p[i*PRIO_W +: PRIO_W];
            end
            for (int i = 0; i < N_CH; i++) begin
                if (p[i*PRIO_W +: PRIO_W] != maxp) cand[i] = 1'b0;
            end
        end
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            idx_w = CH_W'(idx);
            if (!found && cand[idx_w]) begin
                w     = idx_w;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // In IDLE grant_oh_q is zero, so req_m is the full request vector. In OWN it
    // excludes the current owner, which keeps a release from re-granting the owner.
    assign req_m     = bus.req & ~grant_oh_q;
    assign arb_last  = (state_q == OWN) ? grant_id_q : last_ptr_q;
    assign win       = pick(req_m, arb_last, bus.prio);
    assign owner_req = bus.req[grant_id_q];
    assign beat_sum  = {1'b0, beat_cnt_q} + {{Q_W{1'b0}}, bus.beat};
    assign cnt_inc   = (bus.beat && (beat_cnt_q != CNT_MAX)) ? beat_cnt_q + 1'b1 : beat_cnt_q;
    assign quota_hit = (QUOTA != 0) && (beat_sum >= QUOTA_V) && (|req_m);
    assign release_own = bus.advance || !owner_req || quota_hit;

    // One-hot decode of the arbitration winner.
    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    // Next-state and next-grant logic.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        beat_cnt_d = beat_cnt_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d    = OWN;
                    grant_id_d = win;
                    grant_oh_d = win_oh;
                    beat_cnt_d = '0;
                end
            end
            OWN: begin
                if (release_own) begin
                    last_ptr_d = grant_id_q;
                    beat_cnt_d = '0;
                    if (|req_m) begin
                        grant_id_d = win;
                        grant_oh_d = win_oh;
                    end else begin
                        state_d    = IDLE;
                        grant_oh_d = '0;
                    end
                end else begin
                    beat_cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs. Reset clears any grant in progress immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            beat_cnt_q <= '0;
            last_ptr_q <= LAST_RST;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            beat_cnt_q <= beat_cnt_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    assign bus.grant_valid = (state_q == OWN);
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_oh    = grant_oh_q;
    assign bus.beat_cnt    = beat_cnt_q;
    assign dbg_state_o     = state_q;

endmodule
